// File: rtl/ex_divider_stall_unit_pkg.sv
// Shared types for the EX-stage multi-cycle divider: operation encoding and FSM states.
package ex_divider_stall_unit_pkg;

  typedef enum logic [1:0] {
    DivOpDiv  = 2'd0,
    DivOpDivu = 2'd1,
    DivOpRem  = 2'd2,
    DivOpRemu = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } div_state_e;

  function automatic logic op_is_signed(div_op_e op);
    return (op == DivOpDiv) || (op == DivOpRem);
  endfunction

  function automatic logic op_is_rem(div_op_e op);
    return (op == DivOpRem) || (op == DivOpRemu);
  endfunction

endpackage

// File: rtl/ex_divider_stall_unit_divider_iteration.sv
// Combinational restoring-division steps; retires Steps quotient bits per call.
module divider_iteration #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Steps     = 1
) (
  input  logic [DataWidth-1:0] i_rem,
  input  logic [DataWidth-1:0] i_quot,
  input  logic [DataWidth-1:0] i_divisor,
  output logic [DataWidth-1:0] o_rem,
  output logic [DataWidth-1:0] o_quot
);

  logic [DataWidth-1:0] w_rem_acc;
  logic [DataWidth-1:0] w_quot_acc;
  logic [DataWidth:0]   w_shift;
  logic [DataWidth-1:0] w_trial;
  logic                 w_ge;

  always_comb begin
    w_rem_acc  = i_rem;
    w_quot_acc = i_quot;
    w_shift    = '0;
    w_trial    = '0;
    w_ge       = 1'b0;
    for (int unsigned s = 0; s < Steps; s++) begin
      w_shift    = {w_rem_acc, w_quot_acc[DataWidth-1]};
      w_ge       = (w_shift >= {1'b0, i_divisor});
      // When the trial succeeds the difference is below the divisor, so it fits DataWidth bits.
      w_trial    = w_shift[DataWidth-1:0] - i_divisor;
      w_rem_acc  = w_ge ? w_trial : w_shift[DataWidth-1:0];
      w_quot_acc = {w_quot_acc[DataWidth-2:0], w_ge};
    end
  end

  assign o_rem  = w_rem_acc;
  assign o_quot = w_quot_acc;

endmodule

// File: rtl/ex_divider_stall_unit.sv
// EX-stage RV32M divider; holds the pipeline via o_stall_req while iterating and honours flush.
module ex_divider_stall_unit
  import ex_divider_stall_unit_pkg::*;
#(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BitsPerCycle = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  div_op_e              i_op,
  input  logic [DataWidth-1:0] i_src1,
  input  logic [DataWidth-1:0] i_src2,
  input  logic                 i_flush,
  output logic                 o_stall_req,
  output logic                 o_done,
  output logic [DataWidth-1:0] o_result
);

  localparam int unsigned Iter = DataWidth / BitsPerCycle;
  localparam int unsigned CntW = (Iter > 1) ? $clog2(Iter) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Iter - 1);
  localparam logic [DataWidth-1:0] MinVal = {1'b1, {(DataWidth-1){1'b0}}};

  div_state_e           r_state;
  logic [CntW-1:0]      r_cnt;
  div_op_e              r_op;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [DataWidth-1:0] r_rem;
  logic [DataWidth-1:0] r_quot;
  logic [DataWidth-1:0] r_divisor;
  logic [DataWidth-1:0] r_result;

  logic                 w_signed;
  logic                 w_neg1;
  logic                 w_neg2;
  logic [DataWidth-1:0] w_abs1;
  logic [DataWidth-1:0] w_abs2;
  logic                 w_div_zero;
  logic                 w_ovf;
  logic [DataWidth-1:0] w_special_result;
  logic [DataWidth-1:0] w_rem_nxt;
  logic [DataWidth-1:0] w_quot_nxt;
  logic [DataWidth-1:0] w_final_q;
  logic [DataWidth-1:0] w_final_r;

  assign w_signed   = op_is_signed(i_op);
  assign w_neg1     = w_signed & i_src1[DataWidth-1];
  assign w_neg2     = w_signed & i_src2[DataWidth-1];
  assign w_abs1     = w_neg1 ? (~i_src1 + 1'b1) : i_src1;
  assign w_abs2     = w_neg2 ? (~i_src2 + 1'b1) : i_src2;
  assign w_div_zero = (i_src2 == '0);
  assign w_ovf      = w_signed && (i_src1 == MinVal) && (i_src2 == '1);

  // Divide-by-zero takes priority: quotient all ones, remainder is the raw dividend.
  assign w_special_result = w_div_zero ? (op_is_rem(i_op) ? i_src1 : '1)
                                       : (op_is_rem(i_op) ? '0 : MinVal);

  divider_iteration #(
    .DataWidth(DataWidth),
    .Steps    (BitsPerCycle)
  ) u_iter (
    .i_rem    (r_rem),
    .i_quot   (r_quot),
    .i_divisor(r_divisor),
    .o_rem    (w_rem_nxt),
    .o_quot   (w_quot_nxt)
  );

  assign w_final_q = r_neg_q ? (~w_quot_nxt + 1'b1) : w_quot_nxt;
  assign w_final_r = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_op      <= DivOpDiv;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_result  <= '0;
    end else if (i_flush) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_enable) begin
            r_op      <= i_op;
            r_neg_q   <= w_neg1 ^ w_neg2;
            r_neg_r   <= w_neg1;
            r_rem     <= '0;
            r_quot    <= w_abs1;
            r_divisor <= w_abs2;
            r_cnt     <= '0;
            if (w_div_zero || w_ovf) begin
              r_result <= w_special_result;
              r_state  <= StDone;
            end else begin
              r_state <= StRun;
            end
          end
        end
        StRun: begin
          r_rem  <= w_rem_nxt;
          r_quot <= w_quot_nxt;
          if (r_cnt == LastCnt) begin
            r_result <= op_is_rem(r_op) ? w_final_r : w_final_q;
            r_state  <= StDone;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_done      = (r_state == StDone) && !i_flush;
  assign o_result    = o_done ? r_result : '0;
  assign o_stall_req = i_rst_n && i_enable && !i_flush && (r_state != StDone);

endmodule

// File: tb/tb_ex_divider_stall_unit.sv
// Self-checking bench: scoreboard of expected results, one task per scenario, two DUT widths.
module tb_ex_divider_stall_unit;
  import ex_divider_stall_unit_pkg::*;

  localparam logic [31:0] Min = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en1, en2, flush;
  div_op_e     op;
  logic [31:0] src1, src2;
  logic        stall1, done1, stall2, done2;
  logic [31:0] res1, res2;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ex_divider_stall_unit #(.DataWidth(32), .BitsPerCycle(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en1), .i_op(op), .i_src1(src1), .i_src2(src2),
    .i_flush(flush), .o_stall_req(stall1), .o_done(done1), .o_result(res1)
  );

  ex_divider_stall_unit #(.DataWidth(32), .BitsPerCycle(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en2), .i_op(op), .i_src1(src1), .i_src2(src2),
    .i_flush(flush), .o_stall_req(stall2), .o_done(done2), .o_result(res2)
  );

  function automatic logic [31:0] ref_model(div_op_e o, logic [31:0] a, logic [31:0] b);
    logic is_rem;
    logic sgn;
    is_rem = (o == DivOpRem) || (o == DivOpRemu);
    sgn    = (o == DivOpDiv) || (o == DivOpRem);
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == Min && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : Min;
    case (o)
      DivOpDiv:  return $signed(a) / $signed(b);
      DivOpRem:  return $signed(a) % $signed(b);
      DivOpDivu: return a / b;
      default:   return a % b;
    endcase
  endfunction

  // Entered and left at posedge+1; keep leaves enable high for a back-to-back follow-on.
  task automatic run_op(input bit sel, input div_op_e o, input logic [31:0] a,
                        input logic [31:0] b, input bit keep, input string name);
    bit          special;
    bit          got;
    int          lat;
    int          stall_cnt;
    logic        st, dn;
    logic [31:0] rs, ex;
    special = (b == 32'd0) ||
              (((o == DivOpDiv) || (o == DivOpRem)) && a == Min && b == 32'hFFFF_FFFF);
    lat = special ? 1 : (sel ? 17 : 33);
    exp_q.push_back(ref_model(o, a, b));
    op = o; src1 = a; src2 = b;
    if (sel) en2 = 1'b1; else en1 = 1'b1;
    got = 1'b0;
    stall_cnt = 0;
    for (int k = 0; k <= 40 && !got; k++) begin
      @(negedge clk);
      st = sel ? stall2 : stall1;
      dn = sel ? done2 : done1;
      rs = sel ? res2 : res1;
      if (st) stall_cnt++;
      if (dn) begin
        got = 1'b1;
        ex = exp_q.pop_front();
        checks++;
        if (k != lat) begin
          errors++;
          $display("FAIL %s latency: done at cycle %0d, required %0d", name, k, lat);
        end
        checks++;
        if (rs !== ex) begin
          errors++;
          $display("FAIL %s result: got %h, required %h", name, rs, ex);
        end
      end
    end
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no done within 40 cycles, required cycle %0d", name, lat);
      void'(exp_q.pop_front());
    end
    checks++;
    if (stall_cnt != lat) begin
      errors++;
      $display("FAIL %s stall cycles: got %0d, required %0d", name, stall_cnt, lat);
    end
    @(posedge clk); #1;
    if (!keep) begin en1 = 1'b0; en2 = 1'b0; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en1 = 1'b0; en2 = 1'b0; flush = 1'b0;
    op = DivOpDiv; src1 = '0; src2 = '0;
    #12;
    checks++;
    if (stall1 !== 1'b0 || done1 !== 1'b0 || res1 !== 32'd0) begin
      errors++;
      $display("FAIL reset outputs: stall=%b done=%b result=%h, required 0 0 0",
               stall1, done1, res1);
    end
    en1 = 1'b1; en2 = 1'b1;
    #1;
    checks++;
    if (stall1 !== 1'b0 || stall2 !== 1'b0) begin
      errors++;
      $display("FAIL reset stall gating: stall1=%b stall2=%b, required 0 0", stall1, stall2);
    end
    en1 = 1'b0; en2 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_op(0, DivOpDivu, 32'd100, 32'd7, 0, "divu_100_7");
    run_op(0, DivOpRemu, 32'd100, 32'd7, 0, "remu_100_7");
    run_op(0, DivOpDiv, -32'sd7, 32'd2, 0, "div_m7_2");
    run_op(0, DivOpRem, -32'sd7, 32'd2, 0, "rem_m7_2");
    run_op(0, DivOpDiv, 32'd7, -32'sd2, 0, "div_7_m2");
    run_op(0, DivOpRem, 32'd7, -32'sd2, 0, "rem_7_m2");
  endtask

  task automatic test_special();
    run_op(0, DivOpDivu, 32'd5, 32'd0, 0, "divu_by_zero");
    run_op(0, DivOpRem, 32'd5, 32'd0, 0, "rem_by_zero");
    run_op(0, DivOpDiv, Min, 32'hFFFF_FFFF, 0, "div_overflow");
    run_op(0, DivOpRem, Min, 32'hFFFF_FFFF, 0, "rem_overflow");
  endtask

  task automatic test_back_to_back();
    run_op(0, DivOpDivu, 32'd1000, 32'd10, 1, "b2b_first");
    run_op(0, DivOpRem, -32'sd1000, 32'd7, 1, "b2b_second");
    run_op(0, DivOpDiv, 32'd9, 32'd0, 0, "b2b_third");
  endtask

  task automatic test_flush_run();
    op = DivOpDivu; src1 = 32'd100; src2 = 32'd7; en1 = 1'b1;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    #1;
    checks++;
    if (stall1 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL flush_run same cycle: stall=%b done=%b, required 0 0", stall1, done1);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    run_op(0, DivOpDivu, 32'd9, 32'd3, 0, "after_flush_divu_9_3");
  endtask

  task automatic test_flush_done();
    op = DivOpDivu; src1 = 32'd5; src2 = 32'd0; en1 = 1'b1;
    @(posedge clk); #1;
    flush = 1'b1;
    #1;
    checks++;
    if (done1 !== 1'b0 || res1 !== 32'd0) begin
      errors++;
      $display("FAIL flush_done: done=%b result=%h, required 0 0", done1, res1);
    end
    @(posedge clk); #1;
    flush = 1'b0; en1 = 1'b0;
    @(negedge clk);
    checks++;
    if (done1 !== 1'b0) begin
      errors++;
      $display("FAIL flush_done next cycle: done=%b, required 0", done1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    op = DivOpDivu; src1 = 32'd100; src2 = 32'd7; en1 = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (stall1 !== 1'b0 || done1 !== 1'b0 || res1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_run: stall=%b done=%b result=%h, required 0 0 0",
               stall1, done1, res1);
    end
    en1 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, DivOpDivu, 32'd100, 32'd7, 0, "after_reset_divu");
  endtask

  task automatic test_random(input bit sel, input int n);
    div_op_e     o;
    logic [31:0] a, b;
    int          pick;
    for (int i = 0; i < n; i++) begin
      o    = div_op_e'($urandom_range(0, 3));
      a    = ($urandom_range(0, 7) == 0) ? Min : $urandom;
      pick = $urandom_range(0, 9);
      if (pick == 0)      b = 32'd0;
      else if (pick == 1) b = 32'hFFFF_FFFF;
      else if (pick == 2) b = $urandom_range(1, 15);
      else if (pick == 3) b = -$urandom_range(1, 15);
      else                b = $urandom;
      run_op(sel, o, a, b, 0, sel ? "random_bpc2" : "random_bpc1");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_back_to_back();
    test_flush_run();
    test_flush_done();
    test_reset_mid_run();
    test_random(0, 15);
    test_random(1, 15);
    run_op(1, DivOpDivu, 32'd100, 32'd7, 0, "bpc2_divu_100_7");
    run_op(1, DivOpRem, -32'sd7, 32'd2, 0, "bpc2_rem_m7_2");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
